// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the 7-segment scan path (digit width, blank code, slot phase).
// Optional build macro used by the top: LEADING_ZERO_BLANK_EN.
package seven_seg_scanner_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    // Phase of the current digit slot: anodes forced off, or selected digit lit.
    typedef enum logic {
        PH_DEAD = 1'b0,
        PH_LIT  = 1'b1
    } slot_phase_e;

    // All anodes released (active-low enables).
    function automatic logic anode_off_bit();
        return 1'b1;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_divider.sv
// Slot timer for the scanner: divides clk into digit slots and walks the digit index.
// Flags the frame boundary (last cycle of the last slot) and the dead-time phase.
module scan_divider
    import seven_seg_scanner_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYCLES = 500,
    parameter int unsigned IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx_o,
    output logic             boundary_o,
    output slot_phase_e      phase_o
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (div_cnt_q == CNT_MAX) begin
            div_cnt_d = '0;
            idx_d     = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
        end
    end

    assign idx_o      = idx_q;
    assign boundary_o = (div_cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
    assign phase_o    = (div_cnt_q < DEAD_CNT) ? PH_DEAD : PH_LIT;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment scan driver with double-buffered BCD frame and anode dead-time.
// Build macro LEADING_ZERO_BLANK_EN enables suppression of leading zero digits.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic                          load,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [DIGIT_W-1:0]            digit_out,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic                          frame_done,
    output logic                          pending
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FRM_W = DIGIT_W * NUM_DIGITS;

    logic [IDX_W-1:0] idx;
    logic             boundary;
    slot_phase_e      phase;

    scan_divider #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .IDX_W       (IDX_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx_o      (idx),
        .boundary_o (boundary),
        .phase_o    (phase)
    );

    logic [FRM_W-1:0]      shadow_q, shadow_d;
    logic [FRM_W-1:0]      active_q, active_d;
    logic                  pending_q, pending_d;
    logic [DIGIT_W-1:0]    digit_q, digit_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0] lz_mask;

    // A load landing on the boundary cycle bypasses the shadow so it is not lost.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (boundary) begin
            if (load) begin
                active_d = digits_in;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = digits_in;
            pending_d = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; digit 0 is never suppressed.
    always_comb begin
        logic seen_nz;
        int unsigned k;
        lz_mask = '0;
        seen_nz = 1'b0;
        for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
            k = NUM_DIGITS - 1 - j;
            if (active_q[k*DIGIT_W +: DIGIT_W] != '0) begin
                seen_nz = 1'b1;
            end else if (!seen_nz) begin
                lz_mask[k] = 1'b1;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        digit_d      = BLANK_CODE;
        anode_d      = {NUM_DIGITS{anode_off_bit()}};
        frame_done_d = boundary;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == idx) begin
                digit_d = (blank_mask[k] || lz_mask[k]) ? BLANK_CODE
                                                        : active_q[k*DIGIT_W +: DIGIT_W];
                if (phase == PH_LIT) begin
                    anode_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q     <= '1;
            active_q     <= '1;
            pending_q    <= 1'b0;
            digit_q      <= BLANK_CODE;
            anode_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            digit_q      <= digit_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_out  = digit_q;
    assign anode_n    = anode_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  blank_mask;
    logic [3:0]  digit_out;
    logic [3:0]  anode_n;
    logic        frame_done;
    logic        pending;

    seven_seg_scanner #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .DEAD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .load       (load),
        .blank_mask (blank_mask),
        .digit_out  (digit_out),
        .anode_n    (anode_n),
        .frame_done (frame_done),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          c     = 0;     // edges since the last reset edge = internal scan position
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pending;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (pos=%0d)", tag, got, exp, c);
        end
    endtask

    function automatic logic [3:0] lz_of(input logic [15:0] f);
        logic [3:0] m;
        logic       seen;
        m    = 4'b0000;
        seen = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 3; k >= 1; k--) begin
            if (f[k*4 +: 4] != 4'h0) seen = 1'b1;
            else if (!seen) m[k] = 1'b1;
        end
`endif
        return m;
    endfunction

    // One clock; expectations derived from the scan position before the edge.
    task automatic tick();
        logic [3:0] e_an, e_dig, msk;
        logic       e_fd;
        int         s, ix;
        if (!rst_n) begin
            @(posedge clk);
            @(negedge clk);
            c         = 0;
            m_active  = 16'hFFFF;
            m_shadow  = 16'hFFFF;
            m_pending = 1'b0;
            chk("rst_anode", 32'(anode_n), 32'hF);
            chk("rst_digit", 32'(digit_out), 32'hF);
            chk("rst_frame_done", 32'(frame_done), 32'h0);
            chk("rst_pending", 32'(pending), 32'h0);
        end else begin
            s     = c;
            ix    = (s / 8) % 4;
            e_an  = (s % 8 < 2) ? 4'hF : ~(4'b0001 << ix);
            msk   = blank_mask | lz_of(m_active);
            e_dig = msk[ix] ? 4'hF : m_active[ix*4 +: 4];
            e_fd  = (s % 32 == 31);
            if (e_fd) begin
                if (load) m_active = digits_in;
                else if (m_pending) m_active = m_shadow;
                m_pending = 1'b0;
            end else if (load) begin
                m_shadow  = digits_in;
                m_pending = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            c++;
            chk("anode", 32'(anode_n), 32'(e_an));
            chk("digit", 32'(digit_out), 32'(e_dig));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("pending", 32'(pending), 32'(m_pending));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_once(input logic [15:0] v);
        digits_in = v;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        digits_in  = 16'h0000;
        blank_mask = 4'b0000;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: free-running blank scan, two frame_done pulses
        run(70);

        // 2: mid-frame load waits for the boundary
        load_once(16'h1234);
        chk("t2_pending_set", 32'(pending), 32'h1);
        run(60);
        chk("t2_pending_clear", 32'(pending), 32'h0);

        // 3: last of two loads wins
        load_once(16'h5678);
        run(3);
        load_once(16'h9012);
        chk("t3_pending_set", 32'(pending), 32'h1);
        run(70);

        // 4: load exactly on the boundary cycle
        for (int i = 0; i < 32 && (c % 32) != 31; i++) tick();
        load_once(16'h4321);
        chk("t4_pending_stays0", 32'(pending), 32'h0);
        run(40);

        // 5: live blank mask on digit 2
        blank_mask = 4'b0100;
        load_once(16'h1234);
        run(70);
        blank_mask = 4'b0000;
        run(20);

        // 6: leading-zero frame (suppression only with the macro)
        load_once(16'h0070);
        run(70);

        // reset mid-slot, then scan restarts blank from digit 0
        for (int i = 0; i < 8 && (c % 8) != 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
